uart_prog_loader: RTL

Boot-time program loader that sits directly upstream of the instruction memory. It receives a framed program image over a UART line, assembles little-endian 32-bit instruction words and writes them into instruction memory via a write port. While loading, it holds the CPU in reset and releases it only after a load whose checksum verifies.

---
 rtl/loader_pkg.sv | 22 ++
 rtl/uart_rx_byte.sv | 84 ++++++++
 rtl/uart_prog_loader.sv | 137 +++++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
// Shared types and constants for the UART program loader.
// Holds the loader state encoding, the frame sync byte and the bit-period helper.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CNT_LO,
    CNT_HI,
    DATA,
    CSUM,
    DONE,
    ERR
  } state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  // Bit period in core clock cycles, truncated.
  function automatic int calc_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-flop synchronizer, mid-bit sampling timer, LSB-first shifter.
// Emits a one-cycle byte_valid or frame_err pulse one cycle after the stop-bit sample.
module uart_rx_byte #(
  parameter int DIV = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       byte_valid,
  output logic       frame_err
);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  localparam int CW = $clog2(DIV + 1);
  localparam logic [CW-1:0] HALF = CW'(DIV / 2);
  localparam logic [CW-1:0] FULL = CW'(DIV - 1);

  rx_state_t     rx_state;
  logic          rx_s1, rx_s2, rx_s3;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;

  // NOTE: every register here uses non-blocking assignment so all flops update
  // from pre-edge values, exactly like the hardware they describe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state   <= RX_IDLE;
      rx_s1      <= 1'b1;
      rx_s2      <= 1'b1;
      rx_s3      <= 1'b1;
      cnt        <= '0;
      bit_idx    <= '0;
      rx_data    <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_s1      <= rx;
      rx_s2      <= rx_s1;
      rx_s3      <= rx_s2;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          cnt <= '0;
          if (rx_s3 && !rx_s2) rx_state <= RX_START;
        end
        RX_START: begin
          // A start bit that is high again at mid-bit was a glitch.
          if (cnt == HALF) begin
            cnt      <= '0;
            bit_idx  <= '0;
            rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt == FULL) begin
            cnt     <= '0;
            rx_data <= {rx_s2, rx_data[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) rx_state <= RX_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt == FULL) begin
            cnt        <= '0;
            rx_state   <= RX_IDLE;
            byte_valid <= rx_s2;
            frame_err  <= !rx_s2;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_prog_loader.sv
// Boot loader: receives a framed program over UART, writes 32-bit words to instruction
// memory and releases the CPU only after the frame checksum verifies.
module uart_prog_loader
  import loader_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int BAUD        = 115200,
  parameter int ADDR_W      = 10,
  parameter int TIMEOUT_CYC = 16 * calc_div(CLK_HZ, BAUD) * 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  output logic              cpu_hold,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int DIV = calc_div(CLK_HZ, BAUD);
  localparam int TW  = $clog2(TIMEOUT_CYC + 1);
  localparam logic [16:0] MAX_WORDS = 17'(1 << ADDR_W);

  logic [7:0]    rx_data;
  logic          byte_valid;
  logic          frame_err;

  state_t        state;
  logic [7:0]    cnt_lo;
  logic [15:0]   words_left;
  logic [1:0]    lane;
  logic [23:0]   word_buf;
  logic [7:0]    csum;
  logic [TW-1:0] idle_cnt;
  logic [15:0]   count_n;
  logic          timeout_hit;

  uart_rx_byte #(.DIV(DIV)) u_rx (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .rx_data    (rx_data),
    .byte_valid (byte_valid),
    .frame_err  (frame_err)
  );

  assign count_n     = {rx_data, cnt_lo};
  assign timeout_hit = busy && (idle_cnt == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cpu_hold   <= 1'b1;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      cnt_lo     <= '0;
      words_left <= '0;
      lane       <= '0;
      word_buf   <= '0;
      csum       <= '0;
      idle_cnt   <= '0;
    end else begin
      imem_we  <= 1'b0;
      idle_cnt <= (!busy || byte_valid) ? '0 : idle_cnt + 1'b1;
      // Address moves on the cycle after the write pulse so it is stable during it.
      if (imem_we) imem_addr <= imem_addr + 1'b1;

      if (busy && (frame_err || (timeout_hit && !byte_valid))) begin
        state <= ERR;
        err   <= 1'b1;
        busy  <= 1'b0;
      end else if (byte_valid) begin
        case (state)
          IDLE, DONE, ERR: begin
            if (rx_data == SYNC_BYTE) begin
              state     <= CNT_LO;
              busy      <= 1'b1;
              cpu_hold  <= 1'b1;
              done      <= 1'b0;
              err       <= 1'b0;
              imem_addr <= '0;
              csum      <= '0;
              lane      <= '0;
            end
          end
          CNT_LO: begin
            cnt_lo <= rx_data;
            state  <= CNT_HI;
          end
          CNT_HI: begin
            if (count_n == 16'd0) begin
              state <= CSUM;
            end else if ({1'b0, count_n} > MAX_WORDS) begin
              state <= ERR;
              err   <= 1'b1;
              busy  <= 1'b0;
            end else begin
              words_left <= count_n;
              state      <= DATA;
            end
          end
          DATA: begin
            csum     <= csum ^ rx_data;
            lane     <= lane + 2'd1;
            word_buf <= {rx_data, word_buf[23:8]};
            if (lane == 2'd3) begin
              imem_we    <= 1'b1;
              imem_wdata <= {rx_data, word_buf};
              words_left <= words_left - 16'd1;
              if (words_left == 16'd1) state <= CSUM;
            end
          end
          CSUM: begin
            busy <= 1'b0;
            if (rx_data == csum) begin
              state    <= DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state <= ERR;
              err   <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
